// File: rtl/ws2812_rx.sv
//=============================================================================
// Module      : ws2812_rx
// Description : WS2812 single-wire stream decoder. It classifies bits by their
//               high-pulse width and flags the long-low latch gap.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module ws2812_rx #(
    parameter int ONE_THRESH = 6,
    parameter int MIN_HIGH   = 2,
    parameter int MAX_HIGH   = 12,
    parameter int LATCH_LOW  = 64,
    parameter int CNT_W      = $clog2(LATCH_LOW + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    output logic [7:0] data,
    output logic       valid,
    output logic       latch,
    output logic       error
);

    localparam logic [CNT_W-1:0] c_CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_ONE_THRESH = CNT_W'(ONE_THRESH);
    localparam logic [CNT_W-1:0] c_MIN_HIGH   = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] c_MAX_HIGH   = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] c_LATCH_LOW  = CNT_W'(LATCH_LOW);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_WAIT_GAP = 2'd0,
        S_IDLE     = 2'd1,
        S_HIGH     = 2'd2,
        S_LOW      = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_sync1, r_s, r_s_prev;
    logic [CNT_W-1:0] r_hcnt, w_hcnt_nxt;
    logic [CNT_W-1:0] r_lcnt, w_lcnt_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic [2:0]       r_bitcnt, w_bitcnt_nxt;
    logic [7:0]       r_data, w_data_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_latch, w_latch_nxt;
    logic             r_error, w_error_nxt;

    logic             w_rise, w_fall, w_bit;
    logic [CNT_W-1:0] w_hcnt_inc, w_lcnt_inc;
    logic [7:0]       w_shifted;

    assign w_rise     = r_s & ~r_s_prev;
    assign w_fall     = ~r_s & r_s_prev;
    assign w_hcnt_inc = (r_hcnt == c_CNT_MAX) ? r_hcnt : r_hcnt + 1'b1;
    assign w_lcnt_inc = (r_lcnt == c_CNT_MAX) ? r_lcnt : r_lcnt + 1'b1;
    assign w_bit      = (r_hcnt >= c_ONE_THRESH);
    assign w_shifted  = {r_shift[6:0], w_bit};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_s      <= 1'b0;
            r_s_prev <= 1'b0;
            r_state  <= S_WAIT_GAP;
            r_hcnt   <= '0;
            r_lcnt   <= '0;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_latch  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_sync1  <= din;
            r_s      <= r_sync1;
            r_s_prev <= r_s;
            r_state  <= w_state_nxt;
            r_hcnt   <= w_hcnt_nxt;
            r_lcnt   <= w_lcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_data   <= w_data_nxt;
            r_valid  <= w_valid_nxt;
            r_latch  <= w_latch_nxt;
            r_error  <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_hcnt_nxt   = r_hcnt;
        w_lcnt_nxt   = r_lcnt;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_data_nxt   = r_data;
        w_valid_nxt  = 1'b0;
        w_latch_nxt  = 1'b0;
        w_error_nxt  = 1'b0;

        case (r_state)
            // Wait out any truncated pulse before trusting the line again.
            S_WAIT_GAP: begin
                if (r_s) begin
                    w_lcnt_nxt = '0;
                end else if (w_lcnt_inc >= c_LATCH_LOW) begin
                    w_lcnt_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_lcnt_nxt = w_lcnt_inc;
                end
            end
            S_IDLE: begin
                if (w_rise) begin
                    w_hcnt_nxt  = c_CNT_ONE;
                    w_state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_fall) begin
                    if ((r_hcnt < c_MIN_HIGH) || (r_hcnt > c_MAX_HIGH)) begin
                        w_error_nxt  = 1'b1;
                        w_bitcnt_nxt = '0;
                        w_lcnt_nxt   = '0;
                        w_state_nxt  = S_WAIT_GAP;
                    end else begin
                        w_shift_nxt = w_shifted;
                        w_lcnt_nxt  = c_CNT_ONE;
                        w_state_nxt = S_LOW;
                        if (r_bitcnt == 3'd7) begin
                            w_data_nxt   = w_shifted;
                            w_valid_nxt  = 1'b1;
                            w_bitcnt_nxt = '0;
                        end else begin
                            w_bitcnt_nxt = r_bitcnt + 3'd1;
                        end
                    end
                end else begin
                    w_hcnt_nxt = w_hcnt_inc;
                end
            end
            S_LOW: begin
                if (w_rise) begin
                    w_hcnt_nxt  = c_CNT_ONE;
                    w_state_nxt = S_HIGH;
                end else if (w_lcnt_inc >= c_LATCH_LOW) begin
                    w_latch_nxt = 1'b1;
                    w_lcnt_nxt  = '0;
                    w_state_nxt = S_IDLE;
                    if (r_bitcnt != 3'd0) begin
                        w_error_nxt  = 1'b1;
                        w_bitcnt_nxt = '0;
                    end
                end else begin
                    w_lcnt_nxt = w_lcnt_inc;
                end
            end
            default: w_state_nxt = S_WAIT_GAP;
        endcase
    end

    assign data  = r_data;
    assign valid = r_valid;
    assign latch = r_latch;
    assign error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_ws2812_rx.sv
//=============================================================================
// Module      : tb_ws2812_rx
// Description : Directed self-checking bench for the ws2812_rx decoder.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module tb_ws2812_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic [7:0] data;
    logic       valid;
    logic       latch;
    logic       error;

    int checks = 0;
    int errors = 0;
    int n_valid, n_latch, n_error, n_coinc;
    logic [7:0] vq[$];

    always #5 clk = ~clk;

    ws2812_rx dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .data  (data),
        .valid (valid),
        .latch (latch),
        .error (error)
    );

    // Strobe monitor, sampled on the falling edge away from register updates.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid) begin
                n_valid++;
                vq.push_back(data);
            end
            if (latch) n_latch++;
            if (error) n_error++;
            if (latch && error) n_coinc++;
        end
    end

    task automatic clear_counts();
        n_valid = 0;
        n_latch = 0;
        n_error = 0;
        n_coinc = 0;
        vq.delete();
    endtask

    task automatic send_pulse(input int h, input int l);
        din = 1'b1;
        repeat (h) @(negedge clk);
        din = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            if (b[i]) send_pulse(8, 8);
            else      send_pulse(4, 12);
        end
    endtask

    task automatic idle_low(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        din   = 1'b0;
        reset = 1'b1;
        clear_counts();
        repeat (3) @(negedge clk);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (latch !== 1'b0) begin errors++; $display("FAIL reset_latch: got %b expected 0", latch); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
        reset = 1'b0;
        idle_low(64);
    endtask

    task automatic test_single_byte();
        logic [7:0] b;
        b = 8'hA5;
        clear_counts();
        for (int i = 7; i >= 1; i--) begin
            if (b[i]) send_pulse(8, 8);
            else      send_pulse(4, 12);
        end
        din = 1'b1;
        repeat (8) @(negedge clk);
        din = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_valid_early: got %b expected 0", valid); end
        @(negedge clk);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_valid_edge3: got %b expected 1", valid); end
        checks++; if (data !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", data); end
        repeat (5) @(negedge clk);
        idle_low(70);
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL single_valid_count: got %0d expected 1", n_valid); end
        checks++; if (n_error !== 0) begin errors++; $display("FAIL single_error_count: got %0d expected 0", n_error); end
        checks++; if (n_latch !== 1) begin errors++; $display("FAIL single_latch_count: got %0d expected 1", n_latch); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3];
        exp_b = '{8'hFF, 8'h00, 8'h3C};
        clear_counts();
        for (int i = 0; i < 3; i++) send_byte(exp_b[i]);
        idle_low(70);
        checks++; if (n_valid !== 3) begin errors++; $display("FAIL b2b_valid_count: got %0d expected 3", n_valid); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= vq.size()) begin
                errors++; $display("FAIL b2b_data%0d: got none expected %0h", i, exp_b[i]);
            end else if (vq[i] !== exp_b[i]) begin
                errors++; $display("FAIL b2b_data%0d: got %0h expected %0h", i, vq[i], exp_b[i]);
            end
        end
        checks++; if (n_latch !== 1) begin errors++; $display("FAIL b2b_latch_count: got %0d expected 1", n_latch); end
        checks++; if (n_error !== 0) begin errors++; $display("FAIL b2b_error_count: got %0d expected 0", n_error); end
    endtask

    task automatic test_threshold();
        int widths[8];
        // Widths 6,5,6,5,2,12,6,5 decode to 1,0,1,0,0,1,1,0 = 0xA6.
        widths = '{6, 5, 6, 5, 2, 12, 6, 5};
        clear_counts();
        for (int i = 0; i < 8; i++) send_pulse(widths[i], 10);
        idle_low(70);
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL thr_valid_count: got %0d expected 1", n_valid); end
        checks++; if (data !== 8'hA6) begin errors++; $display("FAIL thr_data: got %0h expected a6", data); end
        checks++; if (n_error !== 0) begin errors++; $display("FAIL thr_no_error: got %0d expected 0", n_error); end
        clear_counts();
        send_pulse(1, 10);
        checks++; if (n_error !== 1) begin errors++; $display("FAIL thr_width1_error: got %0d expected 1", n_error); end
        idle_low(70);
        send_pulse(13, 10);
        checks++; if (n_error !== 2) begin errors++; $display("FAIL thr_width13_error: got %0d expected 2", n_error); end
        idle_low(70);
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL thr_bad_valid: got %0d expected 0", n_valid); end
        checks++; if (n_latch !== 0) begin errors++; $display("FAIL thr_bad_latch: got %0d expected 0", n_latch); end
    endtask

    task automatic test_error_recovery();
        clear_counts();
        repeat (3) send_pulse(8, 8);
        send_pulse(1, 10);
        send_byte(8'h81);
        checks++; if (n_error !== 1) begin errors++; $display("FAIL rec_glitch_error: got %0d expected 1", n_error); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL rec_ignored_valid: got %0d expected 0", n_valid); end
        idle_low(64);
        send_byte(8'h81);
        idle_low(70);
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL rec_valid_count: got %0d expected 1", n_valid); end
        checks++; if (data !== 8'h81) begin errors++; $display("FAIL rec_data: got %0h expected 81", data); end
        checks++; if (n_error !== 1) begin errors++; $display("FAIL rec_error_count: got %0d expected 1", n_error); end
        checks++; if (n_latch !== 1) begin errors++; $display("FAIL rec_latch_count: got %0d expected 1", n_latch); end
    endtask

    task automatic test_partial_byte();
        clear_counts();
        send_pulse(8, 8);
        send_pulse(4, 12);
        send_pulse(8, 8);
        send_pulse(8, 8);
        send_pulse(4, 12);
        idle_low(70);
        checks++; if (n_coinc !== 1) begin errors++; $display("FAIL part_latch_with_error: got %0d expected 1", n_coinc); end
        checks++; if (n_latch !== 1) begin errors++; $display("FAIL part_latch_count: got %0d expected 1", n_latch); end
        checks++; if (n_error !== 1) begin errors++; $display("FAIL part_error_count: got %0d expected 1", n_error); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL part_valid_count: got %0d expected 0", n_valid); end
        checks++; if (data !== 8'h81) begin errors++; $display("FAIL part_data_held: got %0h expected 81", data); end
    endtask

    task automatic test_held_high_reset();
        din   = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        din = 1'b0;
        repeat (4) @(negedge clk);
        clear_counts();
        send_byte(8'h42);
        idle_low(10);
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL hh_nogap_valid: got %0d expected 0", n_valid); end
        checks++; if (n_error !== 0) begin errors++; $display("FAIL hh_nogap_error: got %0d expected 0", n_error); end
        checks++; if (n_latch !== 0) begin errors++; $display("FAIL hh_nogap_latch: got %0d expected 0", n_latch); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL hh_nogap_data: got %0h expected 0", data); end
        idle_low(64);
        send_byte(8'h42);
        idle_low(70);
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL hh_valid_count: got %0d expected 1", n_valid); end
        checks++; if (data !== 8'h42) begin errors++; $display("FAIL hh_data: got %0h expected 42", data); end
        checks++; if (n_latch !== 1) begin errors++; $display("FAIL hh_latch_count: got %0d expected 1", n_latch); end
        checks++; if (n_error !== 0) begin errors++; $display("FAIL hh_error_count: got %0d expected 0", n_error); end
    endtask

    initial begin
        reset = 1'b1;
        din   = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_threshold();
        test_error_recovery();
        test_partial_byte();
        test_held_high_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Decodes a WS2812-style single-wire serial stream back into bytes. It is the receive-side counterpart of the LED-chain transmitter.
- Used for loopback self-test of the transmitter output and for sniffing a daisy-chained LED data line.
- Measures each high pulse to classify the bit, assembles bytes MSB-first, and flags the latch (long-low) gap.
- Malformed pulses are reported and the stream is resynchronised.

Parameters:
- ONE_THRESH, 6: synchronised high width in clk cycles at or above which a bit decodes as 1; below it the bit is 0.
- MIN_HIGH, 2: high widths below this are glitches, reported as error.
- MAX_HIGH, 12: high widths above this are reported as error.
- LATCH_LOW, 64: consecutive low cycles that constitute a latch gap.
- CNT_W, $clog2(LATCH_LOW+1): width of the high and low counters. Both counters saturate at 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- din  in  1  serial line, asynchronous to clk
- data  out  8  last completed byte, MSB received first
- valid  out  1  one-cycle strobe: data holds a new byte
- latch  out  1  one-cycle strobe: latch gap detected after at least one pulse
- error  out  1  one-cycle strobe: pulse width violation or partial byte at latch

Behaviour:
- Input path:
  - din passes through a 2-flop synchroniser, giving s.
  - A third flop holds s_prev.
  - rise = s & ~s_prev; fall = ~s & s_prev.
- Reset:
  - state=WAIT_GAP; data=0; valid=latch=error=0.
  - bitcnt=0, shift=0, counters=0.
  - Synchroniser flops are cleared to 0.
- Strobes: valid, latch and error default to 0 every cycle. Each is high for exactly one cycle per event.
- State machine:
  - WAIT_GAP:
    - Counts consecutive cycles with s=0; any s=1 clears the count.
    - When the count reaches LATCH_LOW, go to IDLE with no latch strobe.
    - Purpose: discards a pulse truncated by reset or by an error.
  - IDLE: on rise, go to HIGH with hcnt=1.
  - HIGH: while s=1, hcnt increments. On fall, classify:
    - hcnt < MIN_HIGH or hcnt > MAX_HIGH: error=1, bitcnt=0, go to WAIT_GAP.
    - Otherwise: bit = (hcnt >= ONE_THRESH); shift = {shift[6:0], bit}; bitcnt increments; lcnt=1; go to LOW.
    - When bitcnt was 7 (this is the 8th bit): data <= {shift[6:0], bit}, valid=1, bitcnt=0.
  - LOW:
    - On rise: go to HIGH with hcnt=1.
    - Else lcnt increments. When lcnt reaches LATCH_LOW:
      - latch=1; go to IDLE.
      - If bitcnt != 0: error=1 as well, and the partial byte is discarded (bitcnt=0, data unchanged).
- Latency:
  - Define edge 1 as the first rising clk edge that samples din low.
  - valid and data update on edge 3.
  - latch asserts LATCH_LOW-1 cycles after the cycle in which the last fall was detected.
- MAX_HIGH and the counters:
  - hcnt saturates, so an arbitrarily long high still yields error.
  - A high of MAX_HIGH+1 or more is an error even if the line later falls normally.
- Decoding timing:
  - No bit period check is made; only high width is used.
  - Low widths shorter than LATCH_LOW are accepted as inter-bit gaps.
- Simultaneous events: the 8th bit fall (valid) and any error are mutually exclusive by construction. latch and error may coincide (partial byte).
- Reset mid-byte or mid-pulse: all state is discarded. The block must see a full LATCH_LOW gap before decoding resumes.
- data holds its value until the next complete byte. valid never asserts without a full 8 good bits.

Test Plan:
- Reset, then hold din low 64 cycles. Send byte 0xA5: 1 = 8 high/8 low, 0 = 4 high/12 low. Expect exactly one valid, data=0xA5, on edge 3 after the last fall; no error.
- Send 3 bytes 0xFF, 0x00, 0x3C back to back, then hold low 70 cycles. Expect 3 valid strobes with those values in order, then one latch strobe; no error.
- Threshold check: high widths 5 and 6 cycles decode as 0 and 1. Widths 2 and 12 are accepted; widths 1 and 13 give an error strobe.
- Error recovery:
  - Send a 1-cycle glitch mid-byte: error, no valid.
  - Follow with a full 0x81 byte without a gap: ignored.
  - Then a 64-cycle low gap, then 0x81: valid with data=0x81.
- Send 5 good bits, then 64 low cycles. Expect latch and error on the same cycle, no valid, and data unchanged from the previous byte.
- Hold din high through reset release, then send 0x42 without a gap: no output. Send a 64-low gap, then 0x42: valid with data=0x42.
